// File: rtl/spi_rd_sched_if.sv
// spi_rd_sched_if: requester, response and SPI read-engine signals of spi_rd_sched
interface spi_rd_sched_if #(parameter int DIV_W = 8);
  logic             req0_valid;
  logic [DIV_W-1:0] req0_div;
  logic             req0_ready;
  logic             rsp0_valid;
  logic [7:0]       rsp0_data;
  logic             rsp0_err;
  logic             req1_valid;
  logic [DIV_W-1:0] req1_div;
  logic             req1_ready;
  logic             rsp1_valid;
  logic [7:0]       rsp1_data;
  logic             rsp1_err;
  logic [DIV_W-1:0] sclk_divider;
  logic             rd_en;
  logic             rd_done;
  logic [7:0]       rd_data;
  logic             busy;
  modport master (
    output req0_valid, req0_div, req1_valid, req1_div, rd_done, rd_data,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
           req1_ready, rsp1_valid, rsp1_data, rsp1_err, sclk_divider, rd_en, busy
  );
  modport slave (
    input  req0_valid, req0_div, req1_valid, req1_div, rd_done, rd_data,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
           req1_ready, rsp1_valid, rsp1_data, rsp1_err, sclk_divider, rd_en, busy
  );
endinterface

// File: rtl/spi_rd_sched.sv
// spi_rd_sched: round-robin scheduler of two read requesters onto one SPI read engine
module spi_rd_sched #(
  parameter int               DIV_W       = 8,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(4),
  parameter int               TIMEOUT_CYC = 1024
) (
  input logic           clk,
  input logic           rst,
  spi_rd_sched_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC) > 0 ? $clog2(TIMEOUT_CYC) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t           state;
  logic             owner;
  logic             last;
  logic             grant1;
  logic             finish;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div_sel;
  logic [7:0]       cap_data;
  // requester 1 wins when alone or when requester 0 was served last
  assign grant1         = bus.req1_valid & (~bus.req0_valid | ~last);
  assign bus.req0_ready = (state == IDLE) & bus.req0_valid & ~grant1;
  assign bus.req1_ready = (state == IDLE) & grant1;
  assign bus.busy       = state != IDLE;
  assign div_sel        = grant1 ? bus.req1_div : bus.req0_div;
  assign finish         = bus.rd_done | (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign cap_data       = bus.rd_done ? bus.rd_data : 8'h00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      owner            <= 1'b0;
      last             <= 1'b1;
      cnt              <= '0;
      bus.rd_en        <= 1'b0;
      bus.sclk_divider <= DIV_DEFAULT;
      bus.rsp0_valid   <= 1'b0;
      bus.rsp0_data    <= 8'h00;
      bus.rsp0_err     <= 1'b0;
      bus.rsp1_valid   <= 1'b0;
      bus.rsp1_data    <= 8'h00;
      bus.rsp1_err     <= 1'b0;
    end else begin
      bus.rd_en      <= 1'b0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req0_ready | bus.req1_ready) begin
          owner            <= grant1;
          bus.sclk_divider <= (div_sel == '0) ? DIV_DEFAULT : div_sel;
          bus.rd_en        <= 1'b1;
          state            <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: if (finish) begin
          if (owner) begin
            bus.rsp1_valid <= 1'b1;
            bus.rsp1_data  <= cap_data;
            bus.rsp1_err   <= ~bus.rd_done;
          end else begin
            bus.rsp0_valid <= 1'b1;
            bus.rsp0_data  <= cap_data;
            bus.rsp0_err   <= ~bus.rd_done;
          end
          state <= RESP;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        RESP: begin
          last  <= owner;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_rd_sched.sv
// tb_spi_rd_sched: directed and randomized transactions checked against a transaction-level model
module tb_spi_rd_sched;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic       last_m;
  logic [7:0] exp_data [2];
  logic       exp_err  [2];
  spi_rd_sched_if #(.DIV_W(8)) bus ();
  spi_rd_sched #(.TIMEOUT_CYC(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_idle_outputs(input logic [7:0] ediv);
    chk("idle_rsp0_valid", bus.rsp0_valid, 0);
    chk("idle_rsp1_valid", bus.rsp1_valid, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_rd_en", bus.rd_en, 0);
    chk("idle_sclk", bus.sclk_divider, ediv);
    chk("hold_rsp0_data", bus.rsp0_data, exp_data[0]);
    chk("hold_rsp1_data", bus.rsp1_data, exp_data[1]);
    chk("hold_rsp0_err", bus.rsp0_err, exp_err[0]);
    chk("hold_rsp1_err", bus.rsp1_err, exp_err[1]);
  endtask
  // dly: cycles after rd_en at which the engine strobes rd_done; -1 means never
  task automatic run_txn(input logic v0, input logic v1, input logic [7:0] d0, input logic [7:0] d1,
                         input int dly, input logic [7:0] dat, output logic gw);
    logic       w;
    logic       ok;
    logic [7:0] ediv;
    int         erk;
    int         got;
    w    = (v0 && v1) ? ~last_m : v1;
    ediv = w ? d1 : d0;
    if (ediv == 8'd0) ediv = 8'd4;
    ok   = dly >= 1 && dly <= 16;
    erk  = ok ? dly + 1 : 17;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_div   = d0;
    bus.req1_div   = d1;
    #1;
    chk("req0_ready", bus.req0_ready, !w);
    chk("req1_ready", bus.req1_ready, w);
    gw  = bus.req1_ready;
    got = -1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      chk("rd_en", bus.rd_en, k == 0);
      chk("sclk_hold", bus.sclk_divider, ediv);
      chk("busy", bus.busy, 1);
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        got = k;
        break;
      end
      bus.rd_done = (k == dly);
      bus.rd_data = (k == dly) ? dat : 8'($urandom);
      @(negedge clk);
    end
    bus.rd_done = 1'b0;
    chk("rsp_latency", got, erk);
    chk("rsp0_valid", bus.rsp0_valid, !w);
    chk("rsp1_valid", bus.rsp1_valid, w);
    exp_data[w] = ok ? dat : 8'h00;
    exp_err[w]  = !ok;
    chk("rsp_data", w ? bus.rsp1_data : bus.rsp0_data, exp_data[w]);
    chk("rsp_err", w ? bus.rsp1_err : bus.rsp0_err, exp_err[w]);
    @(negedge clk);
    chk_idle_outputs(ediv);
    last_m = w;
  endtask
  initial begin
    logic       g;
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    int         dly;
    rst = 1'b1;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_div = 0; bus.req1_div = 0;
    bus.rd_done = 0; bus.rd_data = 0;
    last_m = 1'b1;
    exp_data[0] = 0; exp_data[1] = 0; exp_err[0] = 0; exp_err[1] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle_outputs(8'd4);
    chk("reset_ready0", bus.req0_ready, 0);
    chk("reset_ready1", bus.req1_ready, 0);
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 1, 8'd3 + 8'(i), 8'd0, 3 + i, 8'h10 + 8'(i), g);
      chk("contention_order", g, i % 2);
    end
    run_txn(1, 0, 8'd2, 8'd7, 5, 8'hA5, g);
    run_txn(0, 1, 8'd9, 8'd0, 2, 8'h5A, g);
    run_txn(1, 0, 8'd6, 8'd0, -1, 8'hEE, g);
    run_txn(0, 1, 8'd0, 8'd1, 16, 8'hC3, g);
    run_txn(1, 1, 8'd5, 8'd8, 17, 8'h77, g);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        #1;
        chk("novalid_ready0", bus.req0_ready, 0);
        chk("novalid_ready1", bus.req1_ready, 0);
        @(negedge clk);
      end
      v   = 2'($urandom_range(1, 3));
      d0  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      d1  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      dly = $urandom_range(0, 17);
      if (dly == 0) dly = -1;
      run_txn(v[0], v[1], d0, d1, dly, 8'($urandom), g);
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    bus.rd_done = 1'b1;
    bus.rd_data = 8'h99;
    @(negedge clk);
    bus.rd_done = 1'b0;
    chk("stray_busy", bus.busy, 0);
    chk("stray_rsp0", bus.rsp0_valid, 0);
    chk("stray_rsp1", bus.rsp1_valid, 0);
    chk("stray_data0", bus.rsp0_data, exp_data[0]);
    chk("stray_data1", bus.rsp1_data, exp_data[1]);
    bus.req0_valid = 1;
    bus.req0_div   = 8'd9;
    @(negedge clk);
    bus.req0_valid = 0;
    chk("rst_issue_rd_en", bus.rd_en, 1);
    chk("rst_issue_sclk", bus.sclk_divider, 9);
    repeat (3) @(negedge clk);
    chk("rst_wait_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_m = 1'b1;
    exp_data[0] = 0; exp_data[1] = 0; exp_err[0] = 0; exp_err[1] = 0;
    chk_idle_outputs(8'd4);
    bus.rd_done = 1'b1;
    bus.rd_data = 8'h3C;
    @(negedge clk);
    bus.rd_done = 1'b0;
    chk_idle_outputs(8'd4);
    @(negedge clk);
    chk_idle_outputs(8'd4);
    run_txn(1, 1, 8'd2, 8'd3, 4, 8'h42, g);
    chk("post_reset_first_grant", g, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
